// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline: PC/IF/ID load control, ID/EX bubbles,
// back-end freeze on data-memory stalls, terminal halt and dmem timeout detection.
module pipe_hazard_ctrl #(
   parameter int unsigned REG_W      = 3,
   parameter int unsigned CNT_W      = 16,
   parameter int unsigned WAIT_LIMIT = 255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             imem_stall,
   input  logic             dmem_stall,
   input  logic             idex_memread,
   input  logic [REG_W-1:0] idex_rd,
   input  logic [REG_W-1:0] ifid_rs,
   input  logic             ifid_rs_valid,
   input  logic [REG_W-1:0] ifid_rt,
   input  logic             ifid_rt_valid,
   input  logic             ex_redirect,
   input  logic             memwb_halt,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             pipe_hold,
   output logic             halted,
   output logic             err,
   output logic [CNT_W-1:0] stall_count
);

   localparam logic [1:0] RUN    = 2'd0;
   localparam logic [1:0] DSTALL = 2'd1;
   localparam logic [1:0] HALTED = 2'd2;

   // Last wait_cnt value still tolerated; a stall seen at this count trips the timeout.
   localparam logic [7:0] WAIT_LAST = 8'(WAIT_LIMIT - 1);

   logic [1:0]       state_q, state_d;
   logic [7:0]       wait_q, wait_d;
   logic             err_q, err_d;
   logic             halted_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             load_use;

   assign load_use = idex_memread &&
                     ((ifid_rs_valid && (ifid_rs == idex_rd)) ||
                      (ifid_rt_valid && (ifid_rt == idex_rd)));

   always_comb begin
      pc_write   = 1'b1;
      ifid_write = 1'b1;
      ifid_flush = 1'b0;
      idex_flush = 1'b0;
      pipe_hold  = 1'b0;
      state_d    = state_q;
      wait_d     = 8'd0;
      err_d      = err_q;
      if (!rst) begin
         pc_write   = 1'b0;
         ifid_write = 1'b0;
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
         state_d    = RUN;
      end else if (state_q == HALTED) begin
         pc_write   = 1'b0;
         ifid_write = 1'b0;
         pipe_hold  = 1'b1;
         wait_d     = wait_q;
      end else begin
         state_d = RUN;
         if (memwb_halt) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            pipe_hold  = 1'b1;
            state_d    = HALTED;
         end else if (dmem_stall) begin
            // EX is frozen, so redirect and hazard are simply re-evaluated after release.
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            pipe_hold  = 1'b1;
            wait_d     = wait_q + 8'd1;
            state_d    = DSTALL;
            if (wait_q == WAIT_LAST) begin
               err_d   = 1'b1;
               state_d = HALTED;
            end
         end else if (ex_redirect) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
         end else if (load_use) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
         end else if (imem_stall) begin
            pc_write   = 1'b0;
            ifid_flush = 1'b1;
         end
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (rst && (state_q != HALTED) && !pc_write && !(&cnt_q)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= RUN;
         wait_q   <= 8'd0;
         err_q    <= 1'b0;
         halted_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         wait_q   <= wait_d;
         err_q    <= err_d;
         halted_q <= (state_d == HALTED);
         cnt_q    <= cnt_d;
      end
   end

   assign halted      = halted_q;
   assign err         = err_q;
   assign stall_count = cnt_q;

endmodule
